// File: rtl/div_4_seq.sv
// 4-bit unsigned sequential restoring divider: IDLE -> CALC (4 steps) -> DONE.
// Divide-by-zero skips CALC and reports quotient=F, remainder=a.
module div_4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_zero,
    output logic       zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state, state_nx;
    logic [1:0] step;
    logic [3:0] dvd, dsr, q_acc, pr;
    logic [4:0] pr_sh;
    logic       ge;
    logic [3:0] pr_nx, q_nx;

    // After each restore the remainder is < divisor, so it fits in 4 bits;
    // only the shifted value needs the 5th bit for the compare.
    assign pr_sh = {pr, dvd[3]};
    assign ge    = pr_sh >= {1'b0, dsr};
    assign pr_nx = ge ? (pr_sh[3:0] - dsr) : pr_sh[3:0];
    assign q_nx  = {q_acc[2:0], ge};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = (b == 4'd0) ? DONE : CALC;
            CALC:    if (step == 2'd3) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC) || (state == DONE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step      <= '0;
            dvd       <= '0;
            dsr       <= '0;
            q_acc     <= '0;
            pr        <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    dvd      <= a;
                    dsr      <= b;
                    pr       <= '0;
                    q_acc    <= '0;
                    step     <= '0;
                    div_zero <= 1'b0;
                    if (b == 4'd0) begin
                        quotient  <= 4'hF;
                        remainder <= a;
                        div_zero  <= 1'b1;
                    end
                end
                CALC: begin
                    dvd   <= {dvd[2:0], 1'b0};
                    pr    <= pr_nx;
                    q_acc <= q_nx;
                    step  <= step + 2'd1;
                    if (step == 2'd3) begin
                        quotient  <= q_nx;
                        remainder <= pr_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign zero = (quotient == 4'd0);

endmodule

// File: doc/div_4_seq.md
DIV_4_SEQ -- requirements
Module: div_4_seq

Interface
REQ-001 The block SHALL have no parameters; all data widths are fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 a  input  4  unsigned dividend; captured on the accepting edge.
REQ-006 b  input  4  unsigned divisor; captured on the accepting edge.
REQ-007 busy  output  1  high in CALC and DONE states.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 quotient  output  4  unsigned quotient, registered.
REQ-010 remainder  output  4  unsigned remainder, registered.
REQ-011 div_zero  output  1  last accepted operation had b==0.
REQ-012 zero  output  1  quotient==0, combinational from the quotient register.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 IDLE with start=1 at an edge SHALL capture a and b, clear div_zero, and move to CALC with step counter=0, or to DONE if b==0.
REQ-015 IDLE with start=0 SHALL hold all outputs unchanged.
REQ-016 CALC SHALL perform one restoring shift-subtract step per edge, MSB of dividend first, using a 5-bit partial remainder.
- Shift: pr' = {pr[3:0], next dividend bit}.
- Compare: if pr' >= {1'b0,b}, subtract b and shift 1 into the quotient; otherwise shift 0.
REQ-017 After the 4th CALC edge, the block SHALL enter DONE with quotient=a/b and remainder=a%b loaded into the output registers.
REQ-018 Latency SHALL be fixed: with the accepting edge as edge 0, done=1 in the cycle after edge 4 for b!=0 and in the cycle after edge 0 for b==0.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in every other state.
REQ-020 Divide-by-zero SHALL produce quotient=4'hF, remainder=a and div_zero=1, and SHALL NOT enter CALC.
REQ-021 Outputs quotient, remainder, div_zero and zero SHALL hold their values from DONE until the next accepted start.
- During CALC of a new operation they show the previous values, except div_zero, which is cleared at accept.
REQ-022 start asserted in CALC or DONE SHALL be ignored and not queued; a and b changes during CALC SHALL NOT affect the result.
REQ-023 a start held high continuously SHALL be accepted once per IDLE visit, giving back-to-back operations every 6 cycles (b!=0).

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and clear all registers, with priority over start and any in-flight step.
REQ-025 Reset values SHALL be: busy=0, done=0, quotient=0, remainder=0, div_zero=0, zero=1.
REQ-026 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse.
REQ-027 The first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- a=13, b=4, start one cycle -> busy 5 cycles; done after edge 4; quotient=3, remainder=1, zero=0, div_zero=0.
- a=7, b=0 -> done after edge 0; quotient=F, remainder=7, div_zero=1, busy 1 cycle.
- a=3, b=9 -> quotient=0, remainder=3, zero=1; then a=15, b=1 -> quotient=F, remainder=0, zero=0.
- a=15, b=15 accepted; pulse start with a=2, b=1 during CALC -> only one done; quotient=1, remainder=0.
- a=14, b=3 accepted; rst=1 at edge 2 -> next cycle busy=0, done=0, quotient=0, remainder=0, zero=1; no done afterwards.
- Exhaustive sweep of all 256 (a,b) pairs -> quotient/remainder match a/b, a%b (b!=0) or F/a (b==0), with exact done timing.
